// File: rtl/display_scan_driver_pkg.sv
// rtl/display_scan_driver_pkg.sv - shared converter states, display constants and add-3 helper
package display_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam int          DISP_DIGITS = 4;
    localparam int          BIN_W       = 14;
    localparam logic [13:0] DISP_MAX    = 14'd9999;

    // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift
    function automatic logic [15:0] add3_nibbles(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < DISP_DIGITS; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scan_driver_bin2bcd_seq.sv
// rtl/display_scan_driver_bin2bcd_seq.sv - iterative shift-add-3 binary to BCD converter
module bin2bcd_seq
    import display_scan_driver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             load,
    output logic             ready,
    output logic             ovf,
    output logic [15:0]      bcd_out,
    output logic             done
);

    conv_state_t      state_q, state_d;
    logic [BIN_W-1:0] bin_sh_q, bin_sh_d;
    logic [15:0]      acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [29:0]      shift_src;

    // Converter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bin_sh_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_sh_q <= bin_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state: capture clamped value, run 14 correct-and-shift steps, then one commit cycle
    always_comb begin
        state_d   = state_q;
        bin_sh_d  = bin_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        shift_src = {add3_nibbles(acc_q), bin_sh_q};
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_sh_d = (bin > DISP_MAX) ? DISP_MAX : bin;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = (bin > DISP_MAX);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {acc_d, bin_sh_d} = {shift_src[28:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(BIN_W - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = (state_q == ST_COMMIT);
    assign ovf     = ovf_q;
    assign bcd_out = acc_q;

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - BCD conversion and 4-digit multiplexed scan; optional LEADING_ZERO_BLANK_EN
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             ovf,
    output logic [3:0]       bcd,
    output logic             blank,
    output logic [3:0]       an
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   digits_q, digits_d;
    logic [15:0]   conv_bcd;
    logic          conv_done;
    logic          tick;
    logic [DISP_DIGITS-1:0] lz;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (reset),
        .bin     (bin),
        .load    (load),
        .ready   (ready),
        .ovf     (ovf),
        .bcd_out (conv_bcd),
        .done    (conv_done)
    );

    // Prescaler, slot index and committed digit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            idx_q    <= '0;
            digits_q <= '0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
        end
    end

    assign tick = (presc_q == PW'(CLK_DIV - 1));

    // Slot advance on tick; digits only change on the converter's commit cycle
    always_comb begin
        presc_d  = tick ? '0 : presc_q + PW'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        digits_d = conv_done ? conv_bcd : digits_q;
    end

    // Output mux: digit select, active-low anode, blanking
    always_comb begin
        lz  = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lz[3] = (digits_q[15:12] == 4'd0);
        lz[2] = lz[3] && (digits_q[11:8] == 4'd0);
        lz[1] = lz[2] && (digits_q[7:4] == 4'd0);
        lz[0] = 1'b0;
`endif
        bcd   = digits_q[idx_q*4 +: 4];
        an    = en ? ~(4'b0001 << idx_q) : 4'b1111;
        blank = ~en | lz[idx_q];
    end

endmodule
